// File: rtl/bp_be_irf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bp_be_irf_wr_arbiter
// Description : Integer regfile write-port arbiter. Scrubs every register to
//               zero after reset, then shares the single write port between
//               the pipeline writeback, a small buffer of long-latency
//               results, and config-bus debug writes.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_be_irf_wr_arbiter #(
  parameter int dword_width_p    = 64,
  parameter int reg_addr_width_p = 5,
  parameter int ll_fifo_els_p    = 2,
  parameter int starve_limit_p   = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,

  input  logic                              wb_v_i,
  input  logic [reg_addr_width_p-1:0]       wb_addr_i,
  input  logic [dword_width_p-1:0]          wb_data_i,

  input  logic                              ll_v_i,
  output logic                              ll_ready_o,
  input  logic [reg_addr_width_p-1:0]       ll_addr_i,
  input  logic [dword_width_p-1:0]          ll_data_i,

  input  logic                              cfg_w_v_i,
  input  logic [reg_addr_width_p-1:0]       cfg_addr_i,
  input  logic [dword_width_p-1:0]          cfg_data_i,
  output logic                              cfg_w_yumi_o,

  output logic                              wb_stall_o,

  output logic                              rd_w_v_o,
  output logic [reg_addr_width_p-1:0]       rd_addr_o,
  output logic [dword_width_p-1:0]          rd_data_o,

  output logic [(1<<reg_addr_width_p)-1:0]  ll_pending_o,
  output logic                              init_done_o
);

  localparam int c_num_regs = 1 << reg_addr_width_p;
  // Buffer depth is limited to 2..4, so pointer and occupancy widths are small
  localparam int c_ptr_w = (ll_fifo_els_p > 2) ? 2 : 1;
  localparam int c_cnt_w = (ll_fifo_els_p > 3) ? 3 : 2;

  localparam logic [c_ptr_w-1:0]          c_last_ptr     = c_ptr_w'(ll_fifo_els_p - 1);
  localparam logic [c_ptr_w-1:0]          c_ptr_one      = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0]          c_full_cnt     = c_cnt_w'(ll_fifo_els_p);
  localparam logic [c_cnt_w-1:0]          c_cnt_one      = c_cnt_w'(1);
  localparam logic [3:0]                  c_starve_limit = 4'(starve_limit_p);
  localparam logic [reg_addr_width_p-1:0] c_last_idx     = '1;
  localparam logic [reg_addr_width_p-1:0] c_idx_one      = reg_addr_width_p'(1);

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_clear = 2'd1,
    e_run   = 2'd2
  } state_e;

  state_e                         r_state;
  state_e                         w_state_next;
  logic [reg_addr_width_p-1:0]    r_idx;

  logic [reg_addr_width_p-1:0]    r_addr_mem [ll_fifo_els_p];
  logic [dword_width_p-1:0]       r_data_mem [ll_fifo_els_p];
  logic [ll_fifo_els_p-1:0]       r_valid;
  logic [c_ptr_w-1:0]             r_rd_ptr;
  logic [c_ptr_w-1:0]             r_wr_ptr;
  logic [c_cnt_w-1:0]             r_count;

  logic [3:0]                     r_starve;
  logic [3:0]                     w_starve_next;
  logic                           r_stall;

  logic                           w_run;
  logic                           w_empty;
  logic                           w_full;
  logic                           w_enq;
  logic                           w_grant_wb;
  logic                           w_grant_ll;
  logic                           w_grant_cfg;
  logic [reg_addr_width_p-1:0]    w_sel_addr;
  logic [dword_width_p-1:0]       w_sel_data;
  logic [c_num_regs-1:0]          w_pending;

  assign w_run       = (r_state == e_run);
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_full_cnt);
  assign ll_ready_o  = w_run & ~w_full;
  assign w_enq       = ll_v_i & ll_ready_o;
  assign init_done_o = w_run;
  assign wb_stall_o  = r_stall;

  // State register; low reset pulls back to e_reset from anywhere
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= e_reset;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: one idle cycle after reset, scrub every address, then run
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      e_reset: w_state_next = e_clear;
      e_clear: if (r_idx == c_last_idx) w_state_next = e_run;
      e_run:   w_state_next = e_run;
      default: w_state_next = e_reset;
    endcase
  end

  // Scrub index walks every register while clearing, idles at zero otherwise
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_idx <= '0;
    end else if (r_state == e_clear) begin
      r_idx <= r_idx + c_idx_one;
    end else begin
      r_idx <= '0;
    end
  end

  // Port arbitration: stalled head, then writeback, then buffer, then config
  always_comb begin
    w_grant_wb   = 1'b0;
    w_grant_ll   = 1'b0;
    w_grant_cfg  = 1'b0;
    w_sel_addr   = '0;
    w_sel_data   = '0;
    rd_w_v_o     = 1'b0;
    rd_addr_o    = '0;
    rd_data_o    = '0;
    cfg_w_yumi_o = 1'b0;
    case (r_state)
      e_clear: begin
        rd_w_v_o  = 1'b1;
        rd_addr_o = r_idx;
      end
      e_run: begin
        if (r_stall && !w_empty)  w_grant_ll  = 1'b1;
        else if (wb_v_i)          w_grant_wb  = 1'b1;
        else if (!w_empty)        w_grant_ll  = 1'b1;
        else if (cfg_w_v_i)       w_grant_cfg = 1'b1;

        if (w_grant_ll) begin
          w_sel_addr = r_addr_mem[r_rd_ptr];
          w_sel_data = r_data_mem[r_rd_ptr];
        end else if (w_grant_wb) begin
          w_sel_addr = wb_addr_i;
          w_sel_data = wb_data_i;
        end else if (w_grant_cfg) begin
          w_sel_addr = cfg_addr_i;
          w_sel_data = cfg_data_i;
        end

        // x0 is hardwired: the request is consumed but nothing is written
        rd_w_v_o     = (w_grant_wb | w_grant_ll | w_grant_cfg) & (w_sel_addr != '0);
        rd_addr_o    = w_sel_addr;
        rd_data_o    = w_sel_data;
        cfg_w_yumi_o = w_grant_cfg;
      end
      default: ;
    endcase
  end

  // Buffer payload storage; only slots marked valid are ever read
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_addr_mem[r_wr_ptr] <= ll_addr_i;
      r_data_mem[r_wr_ptr] <= ll_data_i;
    end
  end

  // Buffer pointers, occupancy and per-slot valid bits
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr          <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_one;
        r_valid[r_wr_ptr] <= 1'b1;
      end
      if (w_grant_ll) begin
        r_rd_ptr          <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_one;
        r_valid[r_rd_ptr] <= 1'b0;
      end
      case ({w_enq, w_grant_ll})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: ;
      endcase
    end
  end

  // Pending-register vector decoded from the registered buffer contents
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < ll_fifo_els_p; i++) begin
      if (r_valid[i]) w_pending[r_addr_mem[i]] = 1'b1;
    end
  end
  assign ll_pending_o = w_pending;

  // Starvation count: cycles the head waits; cleared by a head grant or empty
  always_comb begin
    w_starve_next = r_starve;
    if (w_empty || w_grant_ll) begin
      w_starve_next = 4'd0;
    end else if (r_starve != 4'hF) begin
      w_starve_next = r_starve + 4'd1;
    end
  end

  // Stall raised the cycle after the count reaches the limit, dropped on grant
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_starve <= 4'd0;
      r_stall  <= 1'b0;
    end else begin
      r_starve <= w_starve_next;
      r_stall  <= (w_starve_next >= c_starve_limit);
    end
  end

  // Upstream protocol checks: no writeback during scrub or while stalled
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!((r_state == e_clear) && wb_v_i));
      assert (!(r_stall && wb_v_i));
    end
  end

endmodule
`default_nettype wire

// File: doc/bp_be_irf_wr_arbiter.md
# bp_be_irf_wr_arbiter

Write-port arbiter and sequencer for the backend integer register file. Shares the single regfile write port between three requesters: the pipeline writeback packet, late-returning long-latency results, and config-bus debug writes. After reset, a scrub FSM zeroes every register before releasing the port. Sits between the writeback/long-latency/cfg sources and the integer regfile's `rd_w_*` port, and exports a pending-write vector for issue hazard checks.

## Interface
- `dword_width_p`, default 64: register data width.
- `reg_addr_width_p`, default 5: register address width; 2^reg_addr_width_p registers.
- `ll_fifo_els_p`, default 2: long-latency result buffer depth, 2..4.
- `starve_limit_p`, default 8: cycles a buffered long-latency result may wait before stall is raised, 1..15.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: synchronous, active-low reset.
- `wb_v_i` in 1: pipeline writeback valid. No backpressure; always consumed.
- `wb_addr_i` in reg_addr_width_p: writeback register address.
- `wb_data_i` in dword_width_p: writeback data.
- `ll_v_i` in 1: long-latency result valid.
- `ll_ready_o` out 1: long-latency buffer can accept. Handshake is `ll_v_i & ll_ready_o`.
- `ll_addr_i` in reg_addr_width_p: long-latency register address.
- `ll_data_i` in dword_width_p: long-latency data.
- `cfg_w_v_i` in 1: config debug write request.
- `cfg_addr_i` in reg_addr_width_p: config write address.
- `cfg_data_i` in dword_width_p: config write data.
- `cfg_w_yumi_o` out 1: config write consumed this cycle.
- `wb_stall_o` out 1: upstream must not assert `wb_v_i` this cycle.
- `rd_w_v_o` out 1: regfile write enable.
- `rd_addr_o` out reg_addr_width_p: regfile write address.
- `rd_data_o` out dword_width_p: regfile write data.
- `ll_pending_o` out 2^reg_addr_width_p: bit i set when a buffered long-latency entry targets register i.
- `init_done_o` out 1: scrub complete; port in normal operation.

## Operation
- FSM states: `e_reset`, `e_clear`, `e_run`.
  - `reset_n_i`=0 forces `e_reset` from any state, including mid-clear or mid-run.
  - `e_reset` → `e_clear` on the first cycle with `reset_n_i`=1.
  - `e_clear` → `e_run` after the index counter writes its last address.
- `e_clear`:
  - Index counter runs 0 → 2^reg_addr_width_p−1, one address per cycle.
  - Each cycle drives `rd_w_v_o`=1, `rd_addr_o`=index, `rd_data_o`=0.
  - `ll_ready_o`=0 and `cfg_w_yumi_o`=0.
  - `wb_v_i`=1 is illegal here; flag with an assertion. The request is ignored.
- `e_run` priority each cycle (`wb_v_i` is always zero when `wb_stall_o`=1):
  1. `wb_stall_o`=1 and buffer non-empty: grant buffer head.
  2. `wb_v_i`: grant writeback.
  3. Buffer non-empty: grant buffer head.
  4. `cfg_w_v_i`: grant config; `cfg_w_yumi_o`=1.
  - No grant → `rd_w_v_o`=0.
- Writes to address 0 are consumed (buffer pop, yumi) but drive `rd_w_v_o`=0. x0 stays zero.
- Long-latency buffer:
  - FIFO of `ll_fifo_els_p` {addr, data} entries.
  - `ll_ready_o` = `e_run` & ~full. No enqueue-while-full bypass; no empty bypass.
  - Enqueue and dequeue in the same cycle is legal.
- `ll_pending_o`: OR of one-hot decodes of all valid entries' addresses, from registered state. An entry's bit clears in the cycle after the entry is granted.
- Starvation counter:
  - 4 bits. Increments each cycle the buffer is non-empty and the head is not granted; saturates.
  - Clears on a head grant or when the buffer is empty.
  - `wb_stall_o` is registered: set on the cycle after the counter reaches `starve_limit_p`, held until the head is granted.
  - The counter also clears on a grant issued under stall.
- Config writes have no starvation guarantee.

## Timing
- Reset values (while `reset_n_i`=0 and in `e_reset`): every output is 0, the buffer is empty, and the counters are 0.
- Reset released at edge T: clear writes occur in cycles T..T+31 (default width). `init_done_o`=1 and `ll_ready_o`=1 from T+32.
- Writeback path is combinational: `wb_*` in cycle N drives `rd_w_*` in cycle N.
- Long-latency path latency is ≥1 cycle: enqueue at cycle N, earliest write at N+1.
- Config yumi is in the same cycle as its write.
- Starvation timing, starve_limit_p=8, wb asserted every cycle:
  - Head enqueued at N, counter reaches 8 at N+8.
  - `wb_stall_o`=1 at N+9; head written at N+9; `wb_stall_o`=0 at N+10.
- Upstream `wb_v_i` while `wb_stall_o`=1 is a protocol violation; flag with an assertion.

## Test plan
- Reset scrub: release reset, then check 32 consecutive writes with addr 0..31 and data 0. `init_done_o` rises at cycle 32, `ll_ready_o`=1 the same cycle. Reassert reset at clear index 10 → all outputs 0, scrub restarts at addr 0.
- Priority: wb(addr 3, 0xAA), ll(addr 4, 0xBB) and cfg(addr 5, 0xCC) all valid at cycle N.
  - Cycle N: write 3/0xAA.
  - Cycle N+1 (wb idle): write 4/0xBB.
  - Cycle N+2: write 5/0xCC, `cfg_w_yumi_o`=1.
  - `ll_pending_o[4]`=1 during N+1, 0 at N+2.
- Buffer full: wb every cycle, two ll enqueues (addr 7, 8).
  - `ll_ready_o`=0 after the second enqueue.
  - `ll_pending_o`=bits 7 and 8.
- Starvation (wb continuous, limit 8): ll enqueued at N → `wb_stall_o`=1 at N+9 with the ll write that cycle, `wb_stall_o`=0 at N+10.
- x0: wb addr 0 → `rd_w_v_o`=0. cfg addr 0 → yumi=1, no write. ll addr 0 → popped, no write, pending bit 0 clears.
- Simultaneous enqueue/dequeue with the buffer full and wb idle: head written, new entry accepted only the next cycle (ready low while full), order preserved.
